// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: register offsets,
// TCON bit positions and the packed TCON register layout.
package timer_pkg;

  localparam logic [4:0] TH_OFFSET      = 5'h00;
  localparam logic [4:0] TL_OFFSET      = 5'h04;
  localparam logic [4:0] TCON_OFFSET    = 5'h08;
  localparam logic [4:0] SYSTICK_OFFSET = 5'h14;

  // The window is 0x18 bytes wide, i.e. six 32-bit words.
  localparam int unsigned WINDOW_WORDS = 6;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic st;
    logic ie;
    logic en;
  } tcon_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by PRESCALE while enabled; held at zero when disabled so
// the first tick lands exactly PRESCALE cycles after enable rises.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // With PRESCALE=1 the count never leaves zero, so tick degenerates to en.
  assign tick = en && (count == LAST);

endmodule

// File: rtl/timer_peripheral.sv
// Interval timer on the data-memory bus: TH/TL reload counter, TCON control and
// status, free-running SYSTICK, and a level IRQ held until software clears ST.
module timer_peripheral
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] systick;
  tcon_t       tcon;

  logic [29:0] word;
  logic [2:0]  idx;
  logic        hit;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        overflow;
  logic        ovf_set;
  logic        unused_addr;

  // Addresses below the base wrap to a large word offset and miss the window.
  assign word = Address[31:2] - BASE_ADDR[31:2];
  assign hit  = word < 30'(WINDOW_WORDS);
  assign idx  = word[2:0];

  assign unused_addr = ^Address[1:0];

  assign wr_th   = MemWr && hit && (idx == TH_OFFSET[4:2]);
  assign wr_tl   = MemWr && hit && (idx == TL_OFFSET[4:2]);
  assign wr_tcon = MemWr && hit && (idx == TCON_OFFSET[4:2]);

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (tcon.en),
    .tick (tick)
  );

  // A software TL write wins over the count, so it also suppresses overflow.
  assign overflow = tick && (tl == TL_MAX) && !wr_tl;
  assign ovf_set  = overflow && tcon.ie;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (wr_th) begin
        th <= WriteData;
      end

      if (wr_tl) begin
        tl <= WriteData;
      end else if (tick) begin
        tl <= overflow ? th : tl + 32'd1;
      end

      // ST merges the written value with a coincident overflow so no event is lost.
      if (wr_tcon) begin
        tcon.en <= WriteData[TCON_EN];
        tcon.ie <= WriteData[TCON_IE];
        tcon.st <= WriteData[TCON_ST] | ovf_set;
      end else if (ovf_set) begin
        tcon.st <= 1'b1;
      end
    end
  end

  // NOTE: ReadData gets a default before the case so no path can infer a latch.
  always_comb begin
    ReadData = '0;
    if (MemRd && hit) begin
      case (idx)
        TH_OFFSET[4:2]:      ReadData = th;
        TL_OFFSET[4:2]:      ReadData = tl;
        TCON_OFFSET[4:2]:    ReadData = {29'd0, tcon};
        SYSTICK_OFFSET[4:2]: ReadData = systick;
        default:             ReadData = '0;
      endcase
    end
  end

  assign IRQ = tcon.ie & tcon.st;

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: two instances (PRESCALE 1 and 4) on one bus,
// directed scenarios plus random bus traffic against a behavioural model.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE + 32'h00;
  localparam logic [31:0] A_TL = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_SYS = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata [2];
  logic        irq [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_peripheral #(.PRESCALE(1), .BASE_ADDR(BASE)) dut_p1 (
    .clk(clk), .reset(rst_n), .Address(addr), .WriteData(wdata),
    .MemWr(wr), .MemRd(rd_en), .ReadData(rdata[0]), .IRQ(irq[0])
  );

  timer_peripheral #(.PRESCALE(4), .BASE_ADDR(BASE)) dut_p4 (
    .clk(clk), .reset(rst_n), .Address(addr), .WriteData(wdata),
    .MemWr(wr), .MemRd(rd_en), .ReadData(rdata[1]), .IRQ(irq[1])
  );

  // Reference model state, one slot per instance.
  longint      pre [2] = '{1, 4};
  logic [31:0] m_th [2];
  logic [31:0] m_tl [2];
  logic [31:0] m_sys [2];
  bit          m_en [2];
  bit          m_ie [2];
  bit          m_st [2];
  longint      m_run [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_sys[i] = '0;
      m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0; m_run[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(int i, logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'd24) return '0;
    case (off & ~32'd3)
      32'h00:  return m_th[i];
      32'h04:  return m_tl[i];
      32'h08:  return {29'd0, m_st[i], m_ie[i], m_en[i]};
      32'h14:  return m_sys[i];
      default: return '0;
    endcase
  endfunction

  // Advance the model by one clock edge using the bus values presented this cycle.
  task automatic model_step();
    logic [31:0] off;
    bit hit, w_th, w_tl, w_tcon, tick, ovf, ovf_set;
    off = addr - BASE;
    hit = wr && (off < 32'd24);
    w_th = hit && ((off & ~32'd3) == 32'h00);
    w_tl = hit && ((off & ~32'd3) == 32'h04);
    w_tcon = hit && ((off & ~32'd3) == 32'h08);
    for (int i = 0; i < 2; i++) begin
      tick = 0;
      if (m_en[i]) begin
        tick = ((m_run[i] + 1) % pre[i]) == 0;
        m_run[i]++;
      end else begin
        m_run[i] = 0;
      end
      ovf = tick && (m_tl[i] == 32'hFFFF_FFFF) && !w_tl;
      ovf_set = ovf && m_ie[i];
      if (w_tl) m_tl[i] = wdata;
      else if (ovf) m_tl[i] = m_th[i];
      else if (tick) m_tl[i] = m_tl[i] + 1;
      if (w_th) m_th[i] = wdata;
      if (w_tcon) begin
        m_en[i] = wdata[0];
        m_ie[i] = wdata[1];
        m_st[i] = wdata[2] | ovf_set;
      end else if (ovf_set) begin
        m_st[i] = 1;
      end
      m_sys[i] = m_sys[i] + 1;
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("irq%0d", i), {31'd0, irq[i]}, {31'd0, m_ie[i] & m_st[i]});
  endtask

  task automatic write_reg(logic [31:0] a, logic [31:0] d, bit with_read);
    addr = a; wdata = d; wr = 1'b1; rd_en = with_read;
    if (with_read) begin
      #1;
      for (int i = 0; i < 2; i++)
        check($sformatf("rd_during_wr%0d", i), rdata[i], model_read(i, a));
    end
    tick_clk();
    wr = 1'b0; rd_en = 1'b0;
  endtask

  task automatic read_reg(logic [31:0] a, string tag);
    addr = a; rd_en = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("%s%0d", tag, i), rdata[i], model_read(i, a));
    rd_en = 1'b0;
  endtask

  task automatic expect_reg(int i, logic [31:0] a, logic [31:0] exp, string tag);
    addr = a; rd_en = 1'b1;
    #1;
    check(tag, rdata[i], exp);
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] offs [8];
    int k;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'hFFFF_FFFC};
    k = $urandom_range(0, 8);
    if (k == 8) return $urandom;
    return BASE + offs[k] + 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
      default: return 32'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    model_reset();

    // Reset state
    #3;
    read_reg(A_TH, "rst_th");
    read_reg(A_TL, "rst_tl");
    read_reg(A_TCON, "rst_tcon");
    read_reg(A_SYS, "rst_sys");
    check("rst_irq", {31'd0, irq[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick_clk();
    expect_reg(0, A_SYS, 32'd10, "systick10_p1");
    expect_reg(1, A_SYS, 32'd10, "systick10_p4");

    // Overflow with IE set, PRESCALE=1
    write_reg(A_TH, 32'hFFFF_FFF0, 0);
    write_reg(A_TL, 32'hFFFF_FFFE, 0);
    write_reg(A_TCON, 32'd3, 0);
    tick_clk();
    check("irq_cycle2", {31'd0, irq[0]}, 32'd0);
    tick_clk();
    check("irq_cycle3", {31'd0, irq[0]}, 32'd1);
    expect_reg(0, A_TL, 32'hFFFF_FFF0, "tl_reload");
    tick_clk();
    expect_reg(0, A_TL, 32'hFFFF_FFF1, "tl_after_reload");

    // Software clear, then clear coinciding with an overflow
    write_reg(A_TCON, 32'd3, 0);
    check("irq_cleared", {31'd0, irq[0]}, 32'd0);
    write_reg(A_TL, 32'hFFFF_FFFE, 0);
    tick_clk();
    write_reg(A_TCON, 32'd3, 0);
    check("irq_clear_vs_ovf", {31'd0, irq[0]}, 32'd1);
    expect_reg(0, A_TCON, 32'd7, "st_kept");

    // PRESCALE=4 timing, freeze and restart
    write_reg(A_TCON, 32'd0, 0);
    write_reg(A_TL, 32'd0, 0);
    write_reg(A_TCON, 32'd1, 0);
    repeat (3) tick_clk();
    expect_reg(1, A_TL, 32'd0, "p4_tl_3cyc");
    tick_clk();
    expect_reg(1, A_TL, 32'd1, "p4_tl_4cyc");
    repeat (4) tick_clk();
    expect_reg(1, A_TL, 32'd2, "p4_tl_8cyc");
    write_reg(A_TCON, 32'd0, 0);
    repeat (5) tick_clk();
    expect_reg(1, A_TL, 32'd2, "p4_frozen");
    write_reg(A_TCON, 32'd1, 0);
    repeat (3) tick_clk();
    expect_reg(1, A_TL, 32'd2, "p4_restart_3cyc");
    tick_clk();
    expect_reg(1, A_TL, 32'd3, "p4_restart_4cyc");

    // IE=0 overflow, TL write on a tick, TH write on an overflow
    write_reg(A_TCON, 32'd0, 0);
    write_reg(A_TH, 32'h1234_5678, 0);
    write_reg(A_TL, 32'hFFFF_FFFF, 0);
    write_reg(A_TCON, 32'd1, 0);
    tick_clk();
    expect_reg(0, A_TL, 32'h1234_5678, "ie0_reload");
    expect_reg(0, A_TCON, 32'd1, "ie0_st_clear");
    check("ie0_irq", {31'd0, irq[0]}, 32'd0);
    write_reg(A_TL, 32'hAAAA_0000, 0);
    expect_reg(0, A_TL, 32'hAAAA_0000, "tl_wr_on_tick");
    write_reg(A_TL, 32'hFFFF_FFFE, 0);
    tick_clk();
    write_reg(A_TH, 32'h5555_0000, 0);
    expect_reg(0, A_TL, 32'h1234_5678, "th_wr_on_ovf");
    expect_reg(0, A_TH, 32'h5555_0000, "th_new_value");

    // Random bus traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: write_reg(rand_addr(), rand_data(), $urandom_range(0, 3) == 0);
        4, 5: begin
          read_reg(rand_addr(), "rnd_rd");
          tick_clk();
        end
        6: begin
          addr = A_TL; rd_en = 1'b0;
          #1;
          check("rd_idle0", rdata[0], 32'd0);
          check("rd_idle1", rdata[1], 32'd0);
          tick_clk();
        end
        default: tick_clk();
      endcase
    end

    // Asynchronous reset mid-count with IRQ high
    write_reg(A_TCON, 32'd0, 0);
    write_reg(A_TL, 32'hFFFF_FFFE, 0);
    write_reg(A_TCON, 32'd3, 0);
    tick_clk();
    tick_clk();
    check("irq_before_reset", {31'd0, irq[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("irq_async_rst0", {31'd0, irq[0]}, 32'd0);
    check("irq_async_rst1", {31'd0, irq[1]}, 32'd0);
    begin
      logic [31:0] regs [4];
      regs = '{A_TH, A_TL, A_TCON, A_SYS};
      for (int r = 0; r < 4; r++) begin
        addr = regs[r]; rd_en = 1'b1;
        #1;
        check($sformatf("async_rst_reg%0d_p1", r), rdata[0], 32'd0);
        check($sformatf("async_rst_reg%0d_p4", r), rdata[1], 32'd0);
      end
      rd_en = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
